multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/riscv_ctrl_pkg.sv | 70 +++++++
 rtl/instret_counter.sv | 20 ++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states
// and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_e;

  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_PCBACK = 2'b01;
  localparam logic [1:0] A_REGA   = 2'b10;

  localparam logic [1:0] B_REGB = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_ALU_LSB0 = 2'b10;

  localparam logic [2:0] WB_ALUOUT = 3'b000;
  localparam logic [2:0] WB_MDR    = 3'b001;
  localparam logic [2:0] WB_PC     = 3'b010;
  localparam logic [2:0] WB_IMM    = 3'b011;
  localparam logic [2:0] WB_AUIPC  = 3'b100;

  function automatic state_e decode_next(input logic [6:0] op);
    case (op)
      OPC_R:                return S_EXEC_R;
      OPC_I:                return S_EXEC_I;
      OPC_LOAD, OPC_STORE:  return S_MEM_ADDR;
      OPC_BRANCH:           return S_BRANCH;
      OPC_JAL:              return S_JAL;
      OPC_JALR:             return S_JALR;
      OPC_LUI:              return S_LUI;
      OPC_AUIPC:            return S_AUIPC;
      default:              return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps naturally at 2**W.
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n)  count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM. Outputs decode from the current state; the
// memory-facing states also look at mem_ready. Strobes are masked during reset.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [6:0]           opc,
  input  logic                 mem_ready,
  output logic                 EscreveIR,
  output logic                 EscrevePC,
  output logic                 EscrevePCCond,
  output logic                 EscreveReg,
  output logic                 IouD,
  output logic                 LeMem,
  output logic                 EscreveMem,
  output logic [1:0]           OrigAULA,
  output logic [1:0]           OrigBULA,
  output logic [1:0]           OpALU,
  output logic [1:0]           OrigPC,
  output logic [2:0]           MemparaReg,
  output logic                 instr_done,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_dbg
);

  state_e state_q, state_d;
  logic   ir_c, pc_c, pcc_c, reg_c, rd_c, wr_c, done_c;

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ir_c       = 1'b0;
    pc_c       = 1'b0;
    pcc_c      = 1'b0;
    reg_c      = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    done_c     = 1'b0;
    IouD       = 1'b0;
    OrigAULA   = A_PC;
    OrigBULA   = B_REGB;
    OpALU      = ALU_ADD;
    OrigPC     = PC_ALU;
    MemparaReg = WB_ALUOUT;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        rd_c = 1'b1;
        if (mem_ready) begin
          ir_c     = 1'b1;
          pc_c     = 1'b1;
          OrigBULA = B_FOUR;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch/jump target precomputed into ALUOut
        OrigAULA = A_PCBACK;
        OrigBULA = B_IMM;
        state_d  = decode_next(opc);
      end
      S_EXEC_R: begin
        OrigAULA = A_REGA;
        OpALU    = ALU_RTYPE;
        state_d  = S_ALU_WB;
      end
      S_EXEC_I: begin
        OrigAULA = A_REGA;
        OrigBULA = B_IMM;
        OpALU    = ALU_ITYPE;
        state_d  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_c   = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        OrigAULA = A_REGA;
        OrigBULA = B_IMM;
        state_d  = (opc == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        IouD = 1'b1;
        rd_c = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemparaReg = WB_MDR;
        reg_c      = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        IouD = 1'b1;
        wr_c = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        OrigAULA = A_REGA;
        OpALU    = ALU_BR;
        OrigPC   = PC_ALUOUT;
        pcc_c    = 1'b1;
        done_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        reg_c      = 1'b1;
        MemparaReg = WB_PC;
        pc_c       = 1'b1;
        OrigPC     = PC_ALUOUT;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        OrigAULA   = A_REGA;
        OrigBULA   = B_IMM;
        reg_c      = 1'b1;
        MemparaReg = WB_PC;
        pc_c       = 1'b1;
        OrigPC     = PC_ALU_LSB0;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        MemparaReg = WB_IMM;
        reg_c      = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_AUIPC: begin
        MemparaReg = WB_AUIPC;
        reg_c      = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  assign EscreveIR     = reset_n & ir_c;
  assign EscrevePC     = reset_n & pc_c;
  assign EscrevePCCond = reset_n & pcc_c;
  assign EscreveReg    = reset_n & reg_c;
  assign LeMem         = reset_n & rd_c;
  assign EscreveMem    = reset_n & wr_c;
  assign instr_done    = reset_n & done_c;
  assign state_dbg     = state_q;

  instret_counter #(.W(INSTRET_W)) u_instret (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (instr_done),
    .count_o (instret)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle against hand-derived state/strobe/select vectors.
module tb_multicycle_control;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC_R = 4'd2,
                         ST_EXEC_I = 4'd3, ST_ALU_WB = 4'd4,  ST_MEM_ADDR = 4'd5,
                         ST_MEM_READ = 4'd6, ST_MEM_WB = 4'd7, ST_MEM_WRITE = 4'd8,
                         ST_BRANCH = 4'd9, ST_JAL = 4'd10,    ST_JALR = 4'd11,
                         ST_LUI = 4'd12,   ST_AUIPC = 4'd13,  ST_ILLEGAL = 4'd14;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opc = 7'd0;
  logic        mem_ready = 1'b1;

  logic        EscreveIR, EscrevePC, EscrevePCCond, EscreveReg, IouD, LeMem, EscreveMem;
  logic [1:0]  OrigAULA, OrigBULA, OpALU, OrigPC;
  logic [2:0]  MemparaReg;
  logic        instr_done, illegal;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  logic        w_ir, w_pc, w_pcc, w_reg, w_iord, w_rd, w_wr, w_done, w_ill;
  logic [1:0]  w_a, w_b, w_op, w_opc;
  logic [2:0]  w_mpr;
  logic [3:0]  instret4;
  logic [3:0]  w_state;

  int tests = 0;
  int fails = 0;

  // {IR, PC, PCCond, Reg, IouD, LeMem, EscreveMem, instr_done}
  logic [7:0] strb;
  // {OrigAULA, OrigBULA, OpALU, OrigPC}
  logic [7:0] sel;
  assign strb = {EscreveIR, EscrevePC, EscrevePCCond, EscreveReg, IouD, LeMem, EscreveMem, instr_done};
  assign sel  = {OrigAULA, OrigBULA, OpALU, OrigPC};

  always #5 clock = ~clock;

  multicycle_control #(.INSTRET_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .opc(opc), .mem_ready(mem_ready),
    .EscreveIR(EscreveIR), .EscrevePC(EscrevePC), .EscrevePCCond(EscrevePCCond),
    .EscreveReg(EscreveReg), .IouD(IouD), .LeMem(LeMem), .EscreveMem(EscreveMem),
    .OrigAULA(OrigAULA), .OrigBULA(OrigBULA), .OpALU(OpALU), .OrigPC(OrigPC),
    .MemparaReg(MemparaReg), .instr_done(instr_done), .illegal(illegal),
    .instret(instret), .state_dbg(state_dbg)
  );

  multicycle_control #(.INSTRET_W(4)) dut_w4 (
    .clock(clock), .reset_n(reset_n), .opc(opc), .mem_ready(mem_ready),
    .EscreveIR(w_ir), .EscrevePC(w_pc), .EscrevePCCond(w_pcc),
    .EscreveReg(w_reg), .IouD(w_iord), .LeMem(w_rd), .EscreveMem(w_wr),
    .OrigAULA(w_a), .OrigBULA(w_b), .OpALU(w_op), .OrigPC(w_opc),
    .MemparaReg(w_mpr), .instr_done(w_done), .illegal(w_ill),
    .instret(instret4), .state_dbg(w_state)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; opc = 7'b0110011; mem_ready = 1'b1;
    tick; tick;
    tests++; if ({state_dbg, strb} !== {ST_FETCH, 8'b0000_0000}) begin fails++;
      $display("FAIL reset_held: got %h want %h", {state_dbg, strb}, {ST_FETCH, 8'b0000_0000}); end
    tests++; if (instret !== 32'd0) begin fails++;
      $display("FAIL reset_instret: got %0d want 0", instret); end
    reset_n = 1'b1;
    #1;
    tests++; if ({state_dbg, strb} !== {ST_FETCH, 8'b1100_0100}) begin fails++;
      $display("FAIL reset_release_fetch: got %h want %h", {state_dbg, strb}, {ST_FETCH, 8'b1100_0100}); end
  endtask

  // Shared prefix of every instruction; leaves the DUT one cycle past DECODE.
  task automatic test_fetch_decode(input logic [6:0] op, input string nm);
    opc = op; mem_ready = 1'b1;
    #1;
    tests++; if ({state_dbg, strb, sel} !== {ST_FETCH, 8'b1100_0100, 8'b0001_0000}) begin fails++;
      $display("FAIL %s_fetch: got %h want %h", nm, {state_dbg, strb, sel}, {ST_FETCH, 8'b1100_0100, 8'b0001_0000}); end
    tick;
    tests++; if ({state_dbg, strb, sel} !== {ST_DECODE, 8'b0000_0000, 8'b0110_0000}) begin fails++;
      $display("FAIL %s_decode: got %h want %h", nm, {state_dbg, strb, sel}, {ST_DECODE, 8'b0000_0000, 8'b0110_0000}); end
    tick;
  endtask

  task automatic test_add;
    test_fetch_decode(7'b0110011, "add");
    tests++; if ({state_dbg, strb, sel} !== {ST_EXEC_R, 8'b0000_0000, 8'b1000_1000}) begin fails++;
      $display("FAIL add_exec: got %h want %h", {state_dbg, strb, sel}, {ST_EXEC_R, 8'b0000_0000, 8'b1000_1000}); end
    tick;
    tests++; if ({state_dbg, strb, MemparaReg} !== {ST_ALU_WB, 8'b0001_0001, 3'b000}) begin fails++;
      $display("FAIL add_wb: got %h want %h", {state_dbg, strb, MemparaReg}, {ST_ALU_WB, 8'b0001_0001, 3'b000}); end
    tests++; if (instret !== 32'd0) begin fails++;
      $display("FAIL add_instret_before: got %0d want 0", instret); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd1}) begin fails++;
      $display("FAIL add_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd1}); end
  endtask

  task automatic test_exec_i;
    test_fetch_decode(7'b0010011, "addi");
    tests++; if ({state_dbg, strb, sel} !== {ST_EXEC_I, 8'b0000_0000, 8'b1010_1100}) begin fails++;
      $display("FAIL addi_exec: got %h want %h", {state_dbg, strb, sel}, {ST_EXEC_I, 8'b0000_0000, 8'b1010_1100}); end
    tick;
    tests++; if ({state_dbg, strb} !== {ST_ALU_WB, 8'b0001_0001}) begin fails++;
      $display("FAIL addi_wb: got %h want %h", {state_dbg, strb}, {ST_ALU_WB, 8'b0001_0001}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd2}) begin fails++;
      $display("FAIL addi_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd2}); end
  endtask

  task automatic test_load_wait;
    test_fetch_decode(7'b0000011, "lw");
    tests++; if ({state_dbg, strb, sel} !== {ST_MEM_ADDR, 8'b0000_0000, 8'b1010_0000}) begin fails++;
      $display("FAIL lw_addr: got %h want %h", {state_dbg, strb, sel}, {ST_MEM_ADDR, 8'b0000_0000, 8'b1010_0000}); end
    tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      tests++; if ({state_dbg, strb} !== {ST_MEM_READ, 8'b0000_1100}) begin fails++;
        $display("FAIL lw_read_%0d: got %h want %h", i, {state_dbg, strb}, {ST_MEM_READ, 8'b0000_1100}); end
      tick;
    end
    tests++; if ({state_dbg, strb, MemparaReg} !== {ST_MEM_WB, 8'b0001_0001, 3'b001}) begin fails++;
      $display("FAIL lw_wb: got %h want %h", {state_dbg, strb, MemparaReg}, {ST_MEM_WB, 8'b0001_0001, 3'b001}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd3}) begin fails++;
      $display("FAIL lw_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd3}); end
  endtask

  task automatic test_branch;
    test_fetch_decode(7'b1100011, "beq");
    tests++; if ({state_dbg, strb, sel} !== {ST_BRANCH, 8'b0010_0001, 8'b1000_0101}) begin fails++;
      $display("FAIL beq_branch: got %h want %h", {state_dbg, strb, sel}, {ST_BRANCH, 8'b0010_0001, 8'b1000_0101}); end
    tick;
    #1;
    tests++; if ({state_dbg, strb, instret} !== {ST_FETCH, 8'b1100_0100, 32'd4}) begin fails++;
      $display("FAIL beq_done: got %h want %h", {state_dbg, strb, instret}, {ST_FETCH, 8'b1100_0100, 32'd4}); end
  endtask

  task automatic test_jumps;
    test_fetch_decode(7'b1101111, "jal");
    tests++; if ({state_dbg, strb, sel, MemparaReg} !== {ST_JAL, 8'b0101_0001, 8'b0000_0001, 3'b010}) begin fails++;
      $display("FAIL jal_exec: got %h want %h", {state_dbg, strb, sel, MemparaReg}, {ST_JAL, 8'b0101_0001, 8'b0000_0001, 3'b010}); end
    tick;
    test_fetch_decode(7'b1100111, "jalr");
    tests++; if ({state_dbg, strb, sel, MemparaReg} !== {ST_JALR, 8'b0101_0001, 8'b1010_0010, 3'b010}) begin fails++;
      $display("FAIL jalr_exec: got %h want %h", {state_dbg, strb, sel, MemparaReg}, {ST_JALR, 8'b0101_0001, 8'b1010_0010, 3'b010}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd6}) begin fails++;
      $display("FAIL jumps_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd6}); end
  endtask

  task automatic test_store_reset;
    test_fetch_decode(7'b0100011, "sw");
    tick;
    mem_ready = 1'b0;
    #1;
    tests++; if ({state_dbg, strb} !== {ST_MEM_WRITE, 8'b0000_1010}) begin fails++;
      $display("FAIL sw_wait: got %h want %h", {state_dbg, strb}, {ST_MEM_WRITE, 8'b0000_1010}); end
    tick;
    mem_ready = 1'b1;
    #1;
    tests++; if ({state_dbg, strb} !== {ST_MEM_WRITE, 8'b0000_1011}) begin fails++;
      $display("FAIL sw_ready: got %h want %h", {state_dbg, strb}, {ST_MEM_WRITE, 8'b0000_1011}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd7}) begin fails++;
      $display("FAIL sw_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd7}); end
    test_fetch_decode(7'b0100011, "sw2");
    tick;
    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++; if ({state_dbg, strb} !== {ST_MEM_WRITE, 8'b0000_1000}) begin fails++;
      $display("FAIL sw_reset_mask: got %h want %h", {state_dbg, strb}, {ST_MEM_WRITE, 8'b0000_1000}); end
    tick;
    tests++; if ({state_dbg, strb, instret} !== {ST_FETCH, 8'b0000_0000, 32'd0}) begin fails++;
      $display("FAIL sw_reset_state: got %h want %h", {state_dbg, strb, instret}, {ST_FETCH, 8'b0000_0000, 32'd0}); end
    reset_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  task automatic test_lui_auipc;
    test_fetch_decode(7'b0110111, "lui");
    tests++; if ({state_dbg, strb, MemparaReg} !== {ST_LUI, 8'b0001_0001, 3'b011}) begin fails++;
      $display("FAIL lui_exec: got %h want %h", {state_dbg, strb, MemparaReg}, {ST_LUI, 8'b0001_0001, 3'b011}); end
    tick;
    test_fetch_decode(7'b0010111, "auipc");
    tests++; if ({state_dbg, strb, MemparaReg} !== {ST_AUIPC, 8'b0001_0001, 3'b100}) begin fails++;
      $display("FAIL auipc_exec: got %h want %h", {state_dbg, strb, MemparaReg}, {ST_AUIPC, 8'b0001_0001, 3'b100}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd2}) begin fails++;
      $display("FAIL lui_auipc_done: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd2}); end
  endtask

  task automatic test_fetch_wait;
    mem_ready = 1'b0;
    #1;
    tests++; if ({state_dbg, strb} !== {ST_FETCH, 8'b0000_0100}) begin fails++;
      $display("FAIL fetch_wait: got %h want %h", {state_dbg, strb}, {ST_FETCH, 8'b0000_0100}); end
    tick;
    tests++; if ({state_dbg, instret} !== {ST_FETCH, 32'd2}) begin fails++;
      $display("FAIL fetch_hold: got %h want %h", {state_dbg, instret}, {ST_FETCH, 32'd2}); end
    mem_ready = 1'b1;
  endtask

  task automatic test_wrap;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1; opc = 7'b0110111; mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick; tick; tick;
    end
    tests++; if (instret4 !== 4'd15) begin fails++;
      $display("FAIL wrap_15: got %0d want 15", instret4); end
    tick; tick; tick;
    tests++; if ({instret4, instret} !== {4'd0, 32'd16}) begin fails++;
      $display("FAIL wrap_0: got %h want %h", {instret4, instret}, {4'd0, 32'd16}); end
  endtask

  task automatic test_illegal;
    test_fetch_decode(7'b1111111, "ill");
    for (int i = 0; i < 10; i++) begin
      tests++; if ({state_dbg, strb, illegal} !== {ST_ILLEGAL, 8'b0000_0000, 1'b1}) begin fails++;
        $display("FAIL ill_hold_%0d: got %h want %h", i, {state_dbg, strb, illegal}, {ST_ILLEGAL, 8'b0000_0000, 1'b1}); end
      tick;
    end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    #1;
    tests++; if ({state_dbg, illegal} !== {ST_FETCH, 1'b0}) begin fails++;
      $display("FAIL ill_reset: got %h want %h", {state_dbg, illegal}, {ST_FETCH, 1'b0}); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_exec_i;
    test_load_wait;
    test_branch;
    test_jumps;
    test_store_reset;
    test_lui_auipc;
    test_fetch_wait;
    test_wrap;
    test_illegal;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
